// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight destinations across the post-decode
// stages and produces bypass selects, load-use interlock, branch annul and a memory freeze.
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int BYP_STAGES   = 3,
    parameter int LD_RDY_STAGE = 3,
    parameter int ZR_REG       = 31,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dec_valid,
    input  logic [REG_AW-1:0]       dec_ra,
    input  logic [REG_AW-1:0]       dec_rb,
    input  logic                    dec_ra_used,
    input  logic                    dec_rb_used,
    input  logic [REG_AW-1:0]       dec_rc,
    input  logic                    dec_we,
    input  logic                    dec_is_ld,
    input  logic                    br_taken,
    input  logic                    mem_busy,
    output logic                    stall,
    output logic                    bubble,
    output logic                    annul_fetch,
    output logic [2:0]              byp_sel_a,
    output logic [2:0]              byp_sel_b,
    output logic [BYP_STAGES-1:0]   stage_valid,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        annul_cnt
);

    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZR_REG);

    // Scoreboard, index 1 = exec (youngest) .. BYP_STAGES (oldest)
    logic [BYP_STAGES:1] v_q;
    logic [BYP_STAGES:1] we_q;
    logic [BYP_STAGES:1] ld_q;
    logic [REG_AW-1:0]   rc_q [1:BYP_STAGES];

    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic       haz_a;
    logic       haz_b;
    logic       ld_haz;

    // Scan oldest to youngest so the youngest match is the one left standing;
    // the hazard flag follows the winning entry, so an older match cannot mask it.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int k = BYP_STAGES; k >= 1; k--) begin
            if (dec_ra_used && v_q[k] && we_q[k] && (rc_q[k] == dec_ra) && (dec_ra != ZR)) begin
                sel_a = 3'(k);
                haz_a = ld_q[k] && (k < LD_RDY_STAGE);
            end
            if (dec_rb_used && v_q[k] && we_q[k] && (rc_q[k] == dec_rb) && (dec_rb != ZR)) begin
                sel_b = 3'(k);
                haz_b = ld_q[k] && (k < LD_RDY_STAGE);
            end
        end
    end

    assign ld_haz      = dec_valid && (haz_a || haz_b);
    assign stall       = mem_busy || ld_haz;
    assign bubble      = ld_haz && !mem_busy;
    assign annul_fetch = br_taken && dec_valid && !ld_haz && !mem_busy;
    assign byp_sel_a   = dec_valid ? sel_a : 3'd0;
    assign byp_sel_b   = dec_valid ? sel_b : 3'd0;
    assign stage_valid = v_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            we_q      <= '0;
            ld_q      <= '0;
            for (int k = 1; k <= BYP_STAGES; k++) begin
                rc_q[k] <= '0;
            end
            stall_cnt <= '0;
            annul_cnt <= '0;
        end else if (!mem_busy) begin
            // An interlocked instruction stays in decode; a bubble enters exec instead.
            v_q[1]  <= dec_valid && !ld_haz;
            rc_q[1] <= dec_rc;
            we_q[1] <= dec_we;
            ld_q[1] <= dec_is_ld;
            for (int k = 2; k <= BYP_STAGES; k++) begin
                v_q[k]  <= v_q[k-1];
                rc_q[k] <= rc_q[k-1];
                we_q[k] <= we_q[k-1];
                ld_q[k] <= ld_q[k-1];
            end
            if (ld_haz && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (annul_fetch && !(&annul_cnt)) begin
                annul_cnt <= annul_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against an instruction-list model.
module tb_pipe_hazard_ctrl;
  localparam int S      = 3;
  localparam int LDR    = 3;
  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_valid;
  logic [4:0]    dec_ra, dec_rb, dec_rc;
  logic          dec_ra_used, dec_rb_used, dec_we, dec_is_ld;
  logic          br_taken, mem_busy;
  logic          stall, bubble, annul_fetch;
  logic [2:0]    byp_sel_a, byp_sel_b;
  logic [S-1:0]  stage_valid;
  logic [CW-1:0] stall_cnt, annul_cnt;

  pipe_hazard_ctrl #(
    .REG_AW(5), .BYP_STAGES(S), .LD_RDY_STAGE(LDR), .ZR_REG(31), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ra(dec_ra), .dec_rb(dec_rb),
    .dec_ra_used(dec_ra_used), .dec_rb_used(dec_rb_used), .dec_rc(dec_rc),
    .dec_we(dec_we), .dec_is_ld(dec_is_ld), .br_taken(br_taken), .mem_busy(mem_busy),
    .stall(stall), .bubble(bubble), .annul_fetch(annul_fetch),
    .byp_sel_a(byp_sel_a), .byp_sel_b(byp_sel_b), .stage_valid(stage_valid),
    .stall_cnt(stall_cnt), .annul_cnt(annul_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: list of instructions in flight, position 1 = youngest
  int m_v  [1:S];
  int m_rc [1:S];
  int m_we [1:S];
  int m_ld [1:S];
  int m_stall = 0;
  int m_annul = 0;

  function automatic int youngest(input int src, input bit used);
    if (!used || src == 31) return 0;
    for (int k = 1; k <= S; k++)
      if (m_v[k] != 0 && m_we[k] != 0 && m_rc[k] == src) return k;
    return 0;
  endfunction

  function automatic bit model_haz();
    int ya, yb;
    ya = youngest(int'(dec_ra), dec_ra_used);
    yb = youngest(int'(dec_rb), dec_rb_used);
    if (!dec_valid) return 1'b0;
    return (ya != 0 && m_ld[ya] != 0 && ya < LDR) || (yb != 0 && m_ld[yb] != 0 && yb < LDR);
  endfunction

  initial begin
    for (int k = 1; k <= S; k++) begin
      m_v[k] = 0; m_rc[k] = 0; m_we[k] = 0; m_ld[k] = 0;
    end
  end

  always @(posedge clk) begin
    bit h;
    bit an;
    h  = model_haz();
    an = br_taken && dec_valid && !h && !mem_busy;
    if (rst) begin
      for (int k = 1; k <= S; k++) begin
        m_v[k] = 0; m_rc[k] = 0; m_we[k] = 0; m_ld[k] = 0;
      end
      m_stall = 0;
      m_annul = 0;
    end else if (!mem_busy) begin
      for (int k = S; k >= 2; k--) begin
        m_v[k] = m_v[k-1]; m_rc[k] = m_rc[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1];
      end
      m_v[1]  = (dec_valid && !h) ? 1 : 0;
      m_rc[1] = int'(dec_rc);
      m_we[1] = int'(dec_we);
      m_ld[1] = int'(dec_is_ld);
      if (h && m_stall < CMAX) m_stall++;
      if (an && m_annul < CMAX) m_annul++;
    end
  end

  // scoreboard compare, every cycle once out of the first reset
  always @(negedge clk) begin
    if (check_en) begin
      bit h;
      int ya, yb, sv;
      h  = model_haz();
      ya = dec_valid ? youngest(int'(dec_ra), dec_ra_used) : 0;
      yb = dec_valid ? youngest(int'(dec_rb), dec_rb_used) : 0;
      sv = 0;
      for (int k = 1; k <= S; k++) if (m_v[k] != 0) sv += (1 << (k - 1));
      chk("m_stall", int'(stall), int'(mem_busy || h));
      chk("m_bubble", int'(bubble), int'(h && !mem_busy));
      chk("m_annul_fetch", int'(annul_fetch), int'(br_taken && dec_valid && !h && !mem_busy));
      chk("m_byp_sel_a", int'(byp_sel_a), ya);
      chk("m_byp_sel_b", int'(byp_sel_b), yb);
      chk("m_stage_valid", int'(stage_valid), sv);
      chk("m_stall_cnt", int'(stall_cnt), m_stall);
      chk("m_annul_cnt", int'(annul_cnt), m_annul);
    end
  end

  // driver tasks
  task automatic set_in(input bit v, input int ra, input int rb, input bit rau, input bit rbu,
                        input int rc, input bit we, input bit ld, input bit br, input bit busy);
    dec_valid = v; dec_ra = 5'(ra); dec_rb = 5'(rb); dec_ra_used = rau; dec_rb_used = rbu;
    dec_rc = 5'(rc); dec_we = we; dec_is_ld = ld; br_taken = br; mem_busy = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rnd_reg();
    int r;
    r = int'($urandom_range(0, 8));
    return (r == 8) ? 31 : r;
  endfunction

  initial begin
    rst = 1'b1;
    nop();
    tick(); tick();
    rst = 1'b0;
    check_en = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_stage_valid", int'(stage_valid), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_stall", int'(stall), 0);

    // ADD R1 then dependent ADD R2,R1,R1, then three readers of R1
    set_in(1, 0, 0, 1, 1, 1, 1, 0, 0, 0); tick();
    set_in(1, 1, 1, 1, 1, 2, 1, 0, 0, 0); @(negedge clk);
    chk("add_sel_a1", int'(byp_sel_a), 1);
    chk("add_sel_b1", int'(byp_sel_b), 1);
    chk("add_stall", int'(stall), 0);
    tick();
    set_in(1, 1, 0, 1, 0, 10, 1, 0, 0, 0); @(negedge clk);
    chk("add_sel_a2", int'(byp_sel_a), 2); tick();
    set_in(1, 1, 0, 1, 0, 11, 1, 0, 0, 0); @(negedge clk);
    chk("add_sel_a3", int'(byp_sel_a), 3); tick();
    set_in(1, 1, 0, 1, 0, 12, 1, 0, 0, 0); @(negedge clk);
    chk("add_sel_a0", int'(byp_sel_a), 0); tick();

    // LD R3 then ADD R4,R3,R0: two interlock cycles
    set_in(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); tick();
    set_in(1, 3, 0, 1, 1, 4, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ld_stall", int'(stall), 1);
      chk("ld_bubble", int'(bubble), 1);
      tick();
    end
    @(negedge clk);
    chk("ld_release_stall", int'(stall), 0);
    chk("ld_release_sel_a", int'(byp_sel_a), 3);
    chk("ld_stall_cnt", int'(stall_cnt), 2);
    tick();

    // zero register never matches, even for loads; youngest of two R5 writers wins
    for (int i = 0; i < 3; i++) begin set_in(1, 0, 0, 0, 0, 31, 1, 1, 0, 0); tick(); end
    set_in(1, 31, 31, 1, 1, 13, 1, 0, 0, 0); @(negedge clk);
    chk("zr_sel_a", int'(byp_sel_a), 0);
    chk("zr_sel_b", int'(byp_sel_b), 0);
    chk("zr_stall", int'(stall), 0);
    tick();
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
    set_in(1, 0, 0, 0, 0, 20, 1, 0, 0, 0); tick();
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
    set_in(1, 5, 5, 1, 1, 14, 1, 0, 0, 0); @(negedge clk);
    chk("yw_sel_a", int'(byp_sel_a), 1);
    chk("yw_sel_b", int'(byp_sel_b), 1);
    tick();

    // LD R6 then taken BEQ on R6: annul only once the interlock clears
    set_in(1, 0, 0, 0, 0, 6, 1, 1, 0, 0); tick();
    set_in(1, 6, 0, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("br_annul_held", int'(annul_fetch), 0);
      chk("br_stall", int'(stall), 1);
      tick();
    end
    @(negedge clk);
    chk("br_annul", int'(annul_fetch), 1);
    tick();
    nop(); @(negedge clk);
    chk("br_annul_cnt", int'(annul_cnt), 1);
    tick();

    // LD R7 then consumer frozen by mem_busy for 4 cycles
    set_in(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); tick();
    set_in(1, 7, 0, 1, 0, 15, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_stall", int'(stall), 1);
      chk("busy_bubble", int'(bubble), 0);
      chk("busy_stall_cnt", int'(stall_cnt), 4);
      chk("busy_stage1", int'(stage_valid[0]), 1);
      tick();
    end
    mem_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("busy_after_bubble", int'(bubble), 1);
      tick();
    end
    @(negedge clk);
    chk("busy_after_sel_a", int'(byp_sel_a), 3);
    chk("busy_after_cnt", int'(stall_cnt), 6);
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 9) > 1, rnd_reg(), rnd_reg(), $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0, rnd_reg(), $urandom_range(0, 4) != 0,
             $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom_range(0, 19) < 3);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    // reset mid-stream with every stage valid
    for (int i = 0; i < 3; i++) begin set_in(1, 0, 0, 0, 0, 1, 1, 0, 1, 0); tick(); end
    @(negedge clk);
    chk("pre_rst_valid", int'(stage_valid), 7);
    rst = 1'b1; tick();
    rst = 1'b0;
    set_in(1, 1, 1, 1, 1, 9, 1, 0, 0, 0); @(negedge clk);
    chk("post_rst_valid", int'(stage_valid), 0);
    chk("post_rst_sel_a", int'(byp_sel_a), 0);
    chk("post_rst_stall_cnt", int'(stall_cnt), 0);
    chk("post_rst_annul_cnt", int'(annul_cnt), 0);
    tick();

    // 9 load-use pairs give 18 stall cycles, counter must stop at 15
    for (int i = 0; i < 9; i++) begin
      set_in(1, 0, 0, 0, 0, 8, 1, 1, 0, 0); tick();
      set_in(1, 8, 0, 1, 0, 16, 1, 0, 0, 0); tick(); tick(); tick();
    end
    nop(); @(negedge clk);
    chk("sat_stall_cnt", int'(stall_cnt), 15);
    tick();

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline-control unit for the next-generation Beta core. Replaces the fixed stall/bypass logic hard-wired into decode.
- Tracks in-flight destination registers across BYP_STAGES post-decode stages.
- Generates per-operand bypass selects, load-use interlock, branch annul of fetch, and a global freeze on memory wait.
- Also keeps saturating performance counters. Sits beside decode; its outputs drive fetch, decode, the operand muxes and the stage valid bits.

Parameters:
- REG_AW, 5, register-address width.
- BYP_STAGES, 3, number of post-decode stages tracked (1=exec, 2=mem, 3=wb); legal range 1..7.
- LD_RDY_STAGE, 3, first stage at which load data may be bypassed; legal range 1..BYP_STAGES.
- ZR_REG, 31, hard-wired zero register; never matches and is never bypassed.
- CNT_W, 32, performance-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dec_valid  in  1  decode holds a valid instruction
- dec_ra  in  REG_AW  source A address
- dec_rb  in  REG_AW  source B address
- dec_ra_used  in  1  source A is read
- dec_rb_used  in  1  source B is read
- dec_rc  in  REG_AW  destination address
- dec_we  in  1  instruction writes dec_rc
- dec_is_ld  in  1  instruction is LD/LDR
- br_taken  in  1  decode resolved a taken branch/JMP
- mem_busy  in  1  memory not ready; freezes the whole pipe
- stall  out  1  hold PC, fetch and decode registers
- bubble  out  1  inject NOP into exec
- annul_fetch  out  1  replace the fetched instruction with NOP
- byp_sel_a  out  3  source-A select: 0 = register file, k = stage k
- byp_sel_b  out  3  source-B select, same encoding
- stage_valid  out  BYP_STAGES  valid bit per tracked stage
- stall_cnt  out  CNT_W  cycles with a load-use stall
- annul_cnt  out  CNT_W  annulled fetches

Behaviour:
- Scoreboard: one register entry {valid, rc, we, is_ld} per stage 1..BYP_STAGES.
- On rst, all entries and both counters clear to 0. Combinational outputs then evaluate to 0 because every valid is 0. This applies to a reset asserted mid-operation too.
- Match, stage k, source X: X_used & entry[k].valid & entry[k].we & (entry[k].rc == X) & (X != ZR_REG).
- Bypass: byp_sel_X is the smallest k with a match (youngest wins). It is 0 when there is no match or when dec_valid = 0.
- Load-use hazard (ld_haz): dec_valid and, for either source, the youngest match is a load with k < LD_RDY_STAGE. A match in an older stage never hides a younger load hazard.
- stall = mem_busy | ld_haz.
- bubble = ld_haz & !mem_busy.
- annul_fetch = br_taken & dec_valid & !ld_haz & !mem_busy. br_taken is ignored while stalled, because the branch operands are not yet valid.
- Advance rule, each clock edge when !rst:
  - If mem_busy: all entries hold. The counters hold, including stall_cnt even if ld_haz is true.
  - Otherwise: entry[k] <= entry[k-1] for k ≥ 2; entry[BYP_STAGES] contents fall off.
  - entry[1] <= {dec_valid & !ld_haz, dec_rc, dec_we, dec_is_ld}. A bubble enters as valid = 0.
- Counters: stall_cnt increments when ld_haz & !mem_busy; annul_cnt increments when annul_fetch. Both saturate at all-ones and never wrap.
- Simultaneous events:
  - mem_busy dominates all.
  - ld_haz suppresses annul_fetch.
  - A branch in decode with its own load-use dependency stalls first and annuls on the cycle the hazard clears.
- Latency: all hazard and bypass outputs are combinational from the decode inputs plus the registered scoreboard. The scoreboard updates one cycle after issue.
- Output widths: byp_sel_* fixed at 3 bits. Unused high values are never produced.

Test Plan:
- Reset, then ADD R1 followed by ADD R2,R1,R1 (default params) -> cycle 2 byp_sel_a = byp_sel_b = 1, stall = 0. Then byp_sel = 2, then 3, then 0 on successive non-dependent cycles.
- LD R3 then ADD R4,R3,R0 -> stall = 1 and bubble = 1 for 2 cycles (load in stages 1, 2). Then byp_sel_a = 3, stall = 0, stall_cnt = 2.
- Writes to R31 in every stage, then consumer reading R31 -> byp_sel = 0, no stall. Repeat with R5 in stage 1 and stage 3 -> byp_sel = 1 (youngest wins).
- LD R6 then BEQ on R6 with br_taken = 1 -> annul_fetch = 0 during the 2 stall cycles, 1 on the third cycle, annul_cnt = 1.
- LD R7 in stage 1, consumer in decode, mem_busy held 4 cycles -> scoreboard frozen, stall = 1, bubble = 0, stall_cnt unchanged. Then the normal 2-cycle interlock follows.
- rst pulsed mid-stream with all stages valid -> next cycle stage_valid = 0, byp_sel = 0, counters = 0. Force stall_cnt near all-ones (CNT_W = 4) -> saturates at 15.
